// File: rtl/serial_pkg.sv
// Shared definitions for the serial deserializer: default width, output FSM
// state type and the bit-counter width helper.
package serial_pkg;

  localparam int DEFAULT_WIDTH = 8;

  // Output holding register state: EMPTY (no word held) / FULL (word held).
  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } out_state_e;

  // Width of the partial-word bit counter for a given word width.
  function automatic int cnt_width(input int width);
    return $clog2(width);
  endfunction

endpackage : serial_pkg

// File: rtl/sipo_shift_core.sv
// Serial-in shift register with bit counter and flush. Produces a one-cycle
// word_done strobe together with the completed word; both are valid in the
// same cycle as the completing bit so the consumer can register them on that
// very edge with no extra latency.
module sipo_shift_core
  import serial_pkg::*;
#(
  parameter int WIDTH     = DEFAULT_WIDTH,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        din_i,
  input  logic                        din_valid_i,
  input  logic                        flush_i,
  output logic                        word_done_o,
  output logic [WIDTH-1:0]            word_o,
  output logic [cnt_width(WIDTH)-1:0] bit_cnt_o
);

  localparam int              CW   = cnt_width(WIDTH);
  localparam logic [CW-1:0]   LAST = CW'(WIDTH - 1);

  logic [WIDTH-1:0] sr_q, sr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] shifted;
  logic             done;

  // Next shift-register / counter value; flush wins over an incoming bit.
  always_comb begin
    sr_d  = sr_q;
    cnt_d = cnt_q;
    done  = 1'b0;
    if (MSB_FIRST) begin
      shifted = {sr_q[WIDTH-2:0], din_i};
    end else begin
      shifted = {din_i, sr_q[WIDTH-1:1]};
    end
    if (flush_i) begin
      sr_d  = '0;
      cnt_d = '0;
    end else if (din_valid_i) begin
      if (cnt_q == LAST) begin
        // Word complete: start the next word from a clean register.
        sr_d  = '0;
        cnt_d = '0;
        done  = 1'b1;
      end else begin
        sr_d  = shifted;
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // Shift register and bit counter state.
  always_ff @(posedge clk) begin
    if (reset) begin
      sr_q  <= '0;
      cnt_q <= '0;
    end else begin
      sr_q  <= sr_d;
      cnt_q <= cnt_d;
    end
  end

  assign word_done_o = done;
  assign word_o      = shifted;
  assign bit_cnt_o   = cnt_q;

endmodule : sipo_shift_core

// File: rtl/serial_deserializer.sv
// Serial-in, parallel-out deserializer. Bits are assembled by sipo_shift_core;
// this level holds each completed word in a registered output stage with a
// valid/ready handshake and a sticky overrun flag for dropped words.
//
// Handshake: dout is offered while dout_valid=1 and is consumed on an edge
// where dout_valid && dout_ready; dout stays stable until consumed, and
// dout_ready is ignored while dout_valid=0.
module serial_deserializer
  import serial_pkg::*;
#(
  parameter int WIDTH     = DEFAULT_WIDTH,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        din,
  input  logic                        din_valid,
  input  logic                        flush,
  output logic [WIDTH-1:0]            dout,
  output logic                        dout_valid,
  input  logic                        dout_ready,
  output logic [cnt_width(WIDTH)-1:0] bit_cnt,
  output logic                        overrun
);

  logic             word_done;
  logic [WIDTH-1:0] word;

  out_state_e       state_q;
  logic [WIDTH-1:0] dout_q;
  logic             overrun_q;

  sipo_shift_core #(
    .WIDTH     (WIDTH),
    .MSB_FIRST (MSB_FIRST)
  ) u_core (
    .clk         (clk),
    .reset       (reset),
    .din_i       (din),
    .din_valid_i (din_valid),
    .flush_i     (flush),
    .word_done_o (word_done),
    .word_o      (word),
    .bit_cnt_o   (bit_cnt)
  );

  // Output holding FSM with dout register and sticky overrun.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_EMPTY;
      dout_q    <= '0;
      overrun_q <= 1'b0;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (word_done) begin
            dout_q  <= word;
            state_q <= ST_FULL;
          end
        end
        ST_FULL: begin
          if (word_done && dout_ready) begin
            // Consumer takes the old word as the new one arrives: no bubble.
            dout_q <= word;
          end else if (dout_ready) begin
            state_q <= ST_EMPTY;
          end else if (word_done) begin
            // Nowhere to put the new word; keep the old one, flag the drop.
            overrun_q <= 1'b1;
          end
        end
        default: state_q <= ST_EMPTY;
      endcase
    end
  end

  assign dout       = dout_q;
  assign dout_valid = (state_q == ST_FULL);
  assign overrun    = overrun_q;

endmodule : serial_deserializer

// File: tb/tb_serial_deserializer.sv
// Bench for serial_deserializer, WIDTH=8. Two instances (MSB-first and
// LSB-first) share one stimulus stream and are compared every cycle against a
// bit-list model of the specified behaviour, plus literal checks per scenario.
module tb_serial_deserializer;

  localparam int W = 8;

  // Clock / reset / stimulus signals
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic din = 1'b0;
  logic din_valid = 1'b0;
  logic flush = 1'b0;
  logic dout_ready = 1'b0;

  logic [W-1:0] dout_m, dout_l;
  logic         dv_m, dv_l, ovr_m, ovr_l;
  logic [2:0]   cnt_m, cnt_l;

  int n_tests = 0;
  int n_fail  = 0;
  bit started = 1'b0;

  always #5 clk = ~clk;

  serial_deserializer #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_msb (
    .clk(clk), .reset(reset), .din(din), .din_valid(din_valid), .flush(flush),
    .dout(dout_m), .dout_valid(dv_m), .dout_ready(dout_ready),
    .bit_cnt(cnt_m), .overrun(ovr_m)
  );

  serial_deserializer #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_lsb (
    .clk(clk), .reset(reset), .din(din), .din_valid(din_valid), .flush(flush),
    .dout(dout_l), .dout_valid(dv_l), .dout_ready(dout_ready),
    .bit_cnt(cnt_l), .overrun(ovr_l)
  );

  // Behavioural model: list of received bits, one held word per bit order.
  logic         part_q[$];
  logic [W-1:0] m_word_m = '0;
  logic [W-1:0] m_word_l = '0;
  logic         m_valid = 1'b0;
  logic         m_ovr = 1'b0;
  logic [W-1:0] exp_q[$];   // words expected to be accepted (MSB-first view)

  always @(posedge clk) begin
    logic         done;
    logic         hs;
    logic [W-1:0] wm, wl;
    done = 1'b0;
    wm = '0;
    wl = '0;
    if (reset) begin
      part_q.delete();
      m_word_m = '0;
      m_word_l = '0;
      m_valid  = 1'b0;
      m_ovr    = 1'b0;
      exp_q.delete();
    end else begin
      if (flush) begin
        part_q.delete();
      end else if (din_valid) begin
        part_q.push_back(din);
        if (part_q.size() == W) begin
          for (int k = 0; k < W; k++) begin
            wm[W-1-k] = part_q[k];
            wl[k]     = part_q[k];
          end
          done = 1'b1;
          part_q.delete();
        end
      end
      hs = m_valid && dout_ready;
      if (hs) exp_q.push_back(m_word_m);
      if (done) begin
        if (!m_valid || hs) begin
          m_word_m = wm;
          m_word_l = wl;
          m_valid  = 1'b1;
        end else begin
          m_ovr = 1'b1;
        end
      end else if (hs) begin
        m_valid = 1'b0;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
    end
  endtask

  // Per-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    if (started) begin
      chk("msb_dout",    32'(dout_m), 32'(m_word_m));
      chk("msb_valid",   32'(dv_m),   32'(m_valid));
      chk("msb_bit_cnt", 32'(cnt_m),  32'(part_q.size()));
      chk("msb_overrun", 32'(ovr_m),  32'(m_ovr));
      chk("lsb_dout",    32'(dout_l), 32'(m_word_l));
      chk("lsb_valid",   32'(dv_l),   32'(m_valid));
      chk("lsb_bit_cnt", 32'(cnt_l),  32'(part_q.size()));
      chk("lsb_overrun", 32'(ovr_l),  32'(m_ovr));
    end
  end

  // Driver tasks: inputs change #1 after the rising edge.
  task automatic cycle(input logic b, input logic v, input logic f, input logic r, input logic rst);
    din = b; din_valid = v; flush = f; dout_ready = r; reset = rst;
    @(posedge clk);
    #1;
    din = 1'b0; din_valid = 1'b0; flush = 1'b0; dout_ready = 1'b0; reset = 1'b0;
  endtask

  task automatic do_reset();
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  // Sends w MSB bit first; optional idle gaps; optional ready on last bit.
  task automatic send_word(input logic [W-1:0] w, input bit gaps, input logic ready_last);
    for (int i = W - 1; i >= 0; i--) begin
      if (gaps && i != W - 1) begin
        int g;
        g = $urandom_range(1, 3);
        for (int j = 0; j < g; j++) cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      end
      cycle(w[i], 1'b1, 1'b0, (i == 0) ? ready_last : 1'b0, 1'b0);
    end
  endtask

  initial begin
    do_reset();
    started = 1'b1;
    chk("reset_dout", 32'(dout_m), 32'h0);
    chk("reset_valid", 32'(dv_m), 32'h0);

    // Continuous stream 1,0,1,0,0,1,1,0
    send_word(8'hA6, 1'b0, 1'b0);
    chk("s1_msb_dout", 32'(dout_m), 32'hA6);
    chk("s1_msb_valid", 32'(dv_m), 32'h1);
    chk("s1_msb_cnt", 32'(cnt_m), 32'h0);
    chk("s1_model_word", 32'(m_word_m), 32'hA6);

    // Same bits with idle gaps, LSB-first view
    do_reset();
    send_word(8'hA6, 1'b1, 1'b0);
    chk("s2_lsb_dout", 32'(dout_l), 32'h65);
    chk("s2_model_lsb", 32'(m_word_l), 32'h65);

    // Two words, no ready: overrun, first word kept
    do_reset();
    send_word(8'hA6, 1'b0, 1'b0);
    send_word(8'h3C, 1'b0, 1'b0);
    chk("s3_dout_kept", 32'(dout_m), 32'hA6);
    chk("s3_overrun", 32'(ovr_m), 32'h1);
    cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("s3_valid_after_hs", 32'(dv_m), 32'h0);
    chk("s3_overrun_sticky", 32'(ovr_m), 32'h1);

    // Handshake on the completing edge of the second word
    do_reset();
    send_word(8'hA6, 1'b0, 1'b0);
    send_word(8'h3C, 1'b0, 1'b1);
    chk("s4_valid", 32'(dv_m), 32'h1);
    chk("s4_dout", 32'(dout_m), 32'h3C);
    chk("s4_overrun", 32'(ovr_m), 32'h0);

    // Flush with a coincident valid bit
    do_reset();
    for (int i = 0; i < 5; i++) cycle(1'($urandom_range(0, 1)), 1'b1, 1'b0, 1'b0, 1'b0);
    chk("s5_cnt_before", 32'(cnt_m), 32'h5);
    cycle(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    chk("s5_cnt_flushed", 32'(cnt_m), 32'h0);
    send_word(8'hFF, 1'b0, 1'b0);
    chk("s5_dout", 32'(dout_m), 32'hFF);
    chk("s5_lsb_dout", 32'(dout_l), 32'hFF);

    // Reset mid-word while a word is held
    do_reset();
    send_word(8'hA6, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
    chk("s6_dout", 32'(dout_m), 32'h0);
    chk("s6_valid", 32'(dv_m), 32'h0);
    chk("s6_cnt", 32'(cnt_m), 32'h0);
    chk("s6_overrun", 32'(ovr_m), 32'h0);
    send_word(8'h3C, 1'b0, 1'b0);
    chk("s6_new_word", 32'(dout_m), 32'h3C);

    // Randomized traffic
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      cycle(1'($urandom_range(0, 1)),
            1'($urandom_range(0, 99) < 80),
            1'($urandom_range(0, 99) < 3),
            1'($urandom_range(0, 99) < 50),
            1'($urandom_range(0, 999) < 3));
    end
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_serial_deserializer
